pong_sfx: RTL

Sound-effect sequencer for the pong game. It sits downstream of the collision and scoring logic and drives the mono audio pin. It turns level-type game events into timed square-wave beeps, with fixed priority and per-sound durations counted in video frames. It replaces free-running tone gating with a proper one-shot sequencer, so each event produces exactly one beep of defined length.

---
 rtl/pong_pkg.sv | 33 +++
 rtl/pong_sfx_if.sv | 24 ++
 rtl/pong_tone_gen.sv | 27 ++
 rtl/pong_sfx.sv | 114 +++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong sound-effect sequencer.
package pong_pkg;

    typedef enum logic [1:0] {
        SND_NONE   = 2'd0,
        SND_WALL   = 2'd1,
        SND_PADDLE = 2'd2,
        SND_SCORE  = 2'd3
    } snd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TONE_A = 2'd1,
        ST_TONE_B = 2'd2
    } state_t;

    localparam int DEF_HALF_LO    = 32768;
    localparam int DEF_HALF_HI    = 16384;
    localparam int DEF_DUR_WALL   = 3;
    localparam int DEF_DUR_PADDLE = 4;
    localparam int DEF_DUR_SCORE  = 8;

    // Sound IDs double as priorities, so the highest rising event wins.
    function automatic snd_t pick_winner(input logic rise_wall,
                                         input logic rise_paddle,
                                         input logic rise_score);
        if (rise_score)  return SND_SCORE;
        if (rise_paddle) return SND_PADDLE;
        if (rise_wall)   return SND_WALL;
        return SND_NONE;
    endfunction

endpackage

// File: rtl/pong_sfx_if.sv
// Game-event inputs and audio/status outputs of the sound sequencer.
interface pong_sfx_if;
    import pong_pkg::*;

    logic frame_tick;
    logic evt_wall;
    logic evt_paddle;
    logic evt_score;
    logic mute;
    logic audio;
    logic busy;
    snd_t cur_snd;

    modport master (
        output frame_tick, evt_wall, evt_paddle, evt_score, mute,
        input  audio, busy, cur_snd
    );

    modport slave (
        input  frame_tick, evt_wall, evt_paddle, evt_score, mute,
        output audio, busy, cur_snd
    );

endinterface

// File: rtl/pong_tone_gen.sv
// Half-period divider: phase toggles every 'half' cycles while clr is low.
module pong_tone_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [15:0] half,
    output logic        phase
);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == half - 16'd1) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/pong_sfx.sv
// One-shot beep sequencer: edge-detected game events become prioritised,
// frame-timed square-wave sounds on the audio pin.
module pong_sfx
    import pong_pkg::*;
#(
    parameter int HALF_LO    = DEF_HALF_LO,
    parameter int HALF_HI    = DEF_HALF_HI,
    parameter int DUR_WALL   = DEF_DUR_WALL,
    parameter int DUR_PADDLE = DEF_DUR_PADDLE,
    parameter int DUR_SCORE  = DEF_DUR_SCORE
) (
    input  logic       clk,
    input  logic       rst_n,
    pong_sfx_if.slave  bus
);

    localparam logic [15:0] HALF_LO_W    = 16'(HALF_LO);
    localparam logic [15:0] HALF_HI_W    = 16'(HALF_HI);
    localparam logic [3:0]  DUR_WALL_W   = 4'(DUR_WALL);
    localparam logic [3:0]  DUR_PADDLE_W = 4'(DUR_PADDLE);
    localparam logic [3:0]  DUR_SCORE_W  = 4'(DUR_SCORE);

    logic        evt_wall_q, evt_paddle_q, evt_score_q;
    snd_t        winner;
    state_t      state, state_next;
    snd_t        snd, snd_next;
    logic [3:0]  dur_cnt, dur_load;
    logic        start, to_b, expire;
    logic        tone_clr, phase;
    logic [15:0] half;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_wall_q   <= 1'b0;
            evt_paddle_q <= 1'b0;
            evt_score_q  <= 1'b0;
        end else begin
            evt_wall_q   <= bus.evt_wall;
            evt_paddle_q <= bus.evt_paddle;
            evt_score_q  <= bus.evt_score;
        end
    end

    assign winner = pick_winner(bus.evt_wall & ~evt_wall_q,
                                bus.evt_paddle & ~evt_paddle_q,
                                bus.evt_score & ~evt_score_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            snd   <= SND_NONE;
        end else begin
            state <= state_next;
            snd   <= snd_next;
        end
    end

    // Equal priority restarts the current sound; a start beats a same-cycle expiry.
    always_comb begin
        start      = (winner != SND_NONE) && (winner >= snd);
        expire     = bus.frame_tick && (dur_cnt == 4'd1) && (state != ST_IDLE);
        state_next = state;
        snd_next   = snd;
        to_b       = 1'b0;
        case (winner)
            SND_WALL:   dur_load = DUR_WALL_W;
            SND_PADDLE: dur_load = DUR_PADDLE_W;
            SND_SCORE:  dur_load = DUR_SCORE_W;
            default:    dur_load = 4'd0;
        endcase
        if (start) begin
            state_next = ST_TONE_A;
            snd_next   = winner;
        end else if (expire) begin
            if (state == ST_TONE_A && snd == SND_SCORE) begin
                state_next = ST_TONE_B;
                to_b       = 1'b1;
            end else begin
                state_next = ST_IDLE;
                snd_next   = SND_NONE;
            end
        end
    end

    always_comb begin
        bus.busy    = (state != ST_IDLE);
        bus.cur_snd = snd;
        bus.audio   = phase & ~bus.mute;
        tone_clr    = start || (state_next != state) || (state == ST_IDLE);
        half        = HALF_LO_W;
        if (state == ST_TONE_B || snd == SND_PADDLE) half = HALF_HI_W;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_cnt <= 4'd0;
        end else if (start) begin
            dur_cnt <= dur_load;
        end else if (to_b) begin
            dur_cnt <= DUR_SCORE_W;
        end else if (bus.frame_tick && state != ST_IDLE) begin
            dur_cnt <= dur_cnt - 4'd1;
        end
    end

    pong_tone_gen u_tone (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tone_clr),
        .half  (half),
        .phase (phase)
    );

endmodule
